// File: rtl/scene_sequencer_pkg.sv
// Shared types and constants for the scene sequencer: FSM encoding,
// colour slice width and the scene-advance helper.
package scene_sequencer_pkg;

    localparam int RGB_W = 3;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_SHOW    = 2'd0,
        ST_PENDING = 2'd1,
        ST_BLANK   = 2'd2
    } state_t;

    // Advance to the next scene, wrapping after the last one.
    function automatic logic [SEL_W-1:0] next_scene(input logic [SEL_W-1:0] sel,
                                                    input int num_scenes);
        return (int'(sel) == num_scenes - 1) ? '0 : sel + 1'b1;
    endfunction

endpackage

// File: rtl/scene_sequencer_if.sv
// Video-side bundle of the scene sequencer: pixel timing and scene colours in,
// DAC colour bits and status out.
interface scene_sequencer_if #(
    parameter int NUM_SCENES = 4
);
    import scene_sequencer_pkg::*;

    logic [9:0]                  pixel_x;
    logic [9:0]                  pixel_y;
    logic                        video_on;
    logic [RGB_W*NUM_SCENES-1:0] scene_rgb;
    logic                        red;
    logic                        green;
    logic                        blue;
    logic [SEL_W-1:0]            scene_sel;
    logic                        frame_tick;

    modport master (
        output pixel_x, pixel_y, video_on, scene_rgb,
        input  red, green, blue, scene_sel, frame_tick
    );

    modport slave (
        input  pixel_x, pixel_y, video_on, scene_rgb,
        output red, green, blue, scene_sel, frame_tick
    );

endinterface

// File: rtl/scene_sequencer_button_debounce.sv
// Two-flop synchronizer plus debounce counter for an active-low push button;
// emits the debounced level and a one-cycle pulse on each press.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_0,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
        end
    end

    // Any sample agreeing with the current level restarts the stability count.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync_2;
                press <= ~sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/scene_sequencer.sv
// Selects one of NUM_SCENES colour generators for the DAC, advancing on a
// debounced button press or a frame-count timeout, with one black frame per change.
module scene_sequencer
    import scene_sequencer_pkg::*;
#(
    parameter int NUM_SCENES       = 4,
    parameter int FRAMES_PER_SCENE = 300,
    parameter int DEBOUNCE_CYCLES  = 250000,
    parameter int h_video          = 640,
    parameter int v_video          = 480
) (
    input  logic clk_0,
    input  logic rst,
    input  logic btn_next,
    input  logic auto_en,
    scene_sequencer_if.slave vid
);
    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] sel;
    logic [9:0]       frame_cnt;
    logic             frame_end;
    logic             auto_req;
    logic             advance;
    logic             show_pix;
    logic             btn_level;
    logic             btn_press;
    logic             press_evt;
    logic [RGB_W-1:0] pix;
    logic [RGB_W-1:0] rgb_q;
    logic             tick_q;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button_debounce (
        .clk_0 (clk_0),
        .rst   (rst),
        .btn_n (btn_next),
        .level (btn_level),
        .press (btn_press)
    );

    assign press_evt = btn_press & ~btn_level;
    assign frame_end = vid.video_on
                     && (vid.pixel_x == 10'(h_video - 1))
                     && (vid.pixel_y == 10'(v_video - 1));
    assign auto_req  = auto_en && frame_end
                     && (frame_cnt == 10'(FRAMES_PER_SCENE - 1));

    always_ff @(posedge clk_0) begin
        if (!rst) state <= ST_SHOW;
        else      state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_SHOW: begin
                if (auto_req)       state_nxt = ST_BLANK;
                else if (press_evt) state_nxt = ST_PENDING;
            end
            ST_PENDING: if (frame_end) state_nxt = ST_BLANK;
            ST_BLANK:   if (frame_end) state_nxt = ST_SHOW;
            default:    state_nxt = ST_SHOW;
        endcase
    end

    // Scene changes only on entry to BLANK, so a press and a timeout in one frame advance once.
    always_comb begin
        advance  = 1'b0;
        show_pix = 1'b1;
        case (state)
            ST_SHOW:    advance  = auto_req;
            ST_PENDING: advance  = frame_end;
            ST_BLANK:   show_pix = 1'b0;
            default:    show_pix = 1'b0;
        endcase
    end

    always_ff @(posedge clk_0) begin
        if (!rst)         sel <= '0;
        else if (advance) sel <= next_scene(sel, NUM_SCENES);
    end

    always_ff @(posedge clk_0) begin
        if (!rst)                            frame_cnt <= '0;
        else if (!auto_en || advance)        frame_cnt <= '0;
        else if (frame_end && state == ST_SHOW) frame_cnt <= frame_cnt + 1'b1;
    end

    always_comb begin
        pix = '0;
        for (int k = 0; k < NUM_SCENES; k++) begin
            if (sel == SEL_W'(k)) pix = vid.scene_rgb[k*RGB_W +: RGB_W];
        end
    end

    always_ff @(posedge clk_0) begin
        if (!rst) begin
            rgb_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            rgb_q  <= (vid.video_on && show_pix) ? pix : '0;
            tick_q <= frame_end;
        end
    end

    assign vid.red        = rgb_q[2];
    assign vid.green      = rgb_q[1];
    assign vid.blue       = rgb_q[0];
    assign vid.scene_sel  = sel;
    assign vid.frame_tick = tick_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// Frame-level bench for scene_sequencer on a tiny 8x4 raster: a table of
// per-frame stimulus/expectations plus hand-written reset sequences.
module tb_scene_sequencer;
    import scene_sequencer_pkg::*;

    localparam int NS  = 3;
    localparam int FPS = 2;
    localparam int DEB = 4;
    localparam int HV  = 8;
    localparam int VV  = 4;
    localparam int HT  = 10;
    localparam int VT  = 5;

    logic clk_0    = 1'b0;
    logic rst      = 1'b0;
    logic btn_next = 1'b1;
    logic auto_en  = 1'b0;
    logic patterned = 1'b0;

    scene_sequencer_if #(.NUM_SCENES(NS)) vid ();

    scene_sequencer #(
        .NUM_SCENES       (NS),
        .FRAMES_PER_SCENE (FPS),
        .DEBOUNCE_CYCLES  (DEB),
        .h_video          (HV),
        .v_video          (VV)
    ) dut (
        .clk_0    (clk_0),
        .rst      (rst),
        .btn_next (btn_next),
        .auto_en  (auto_en),
        .vid      (vid)
    );

    always #20 clk_0 = ~clk_0;

    typedef struct {
        logic [2:0] rgb;
        logic       tick;
    } exp_t;

    typedef struct {
        string      name;
        logic       auto_on;
        logic       pat;
        int         press_start;
        int         press_len;
        logic       blank;
        logic [2:0] disp;
        logic [2:0] sel_end;
    } frame_vec_t;

    exp_t       sb_q[$];
    frame_vec_t vecs[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scene 0 is solid red in the plain mode; the patterned mode varies per pixel and per scene.
    function automatic logic [2:0] colour(input int k, input int x, input int y);
        if (patterned) return 3'((x + 2*y + 3*k) % 8);
        return (k == 0) ? 3'b100 : (k == 1) ? 3'b010 : 3'b001;
    endfunction

    task automatic drive_cycle(input string name, input int x, input int y, input logic btn,
                               input logic rst_val, input logic blank, input logic [2:0] disp);
        logic von;
        exp_t e;
        von = (x < HV) && (y < VV);
        vid.pixel_x  = 10'(x);
        vid.pixel_y  = 10'(y);
        vid.video_on = von;
        for (int k = 0; k < NS; k++) vid.scene_rgb[3*k +: 3] = colour(k, x, y);
        btn_next = btn;
        rst      = rst_val;
        e.rgb  = (rst_val && von && !blank) ? colour(int'(disp), x, y) : 3'b000;
        e.tick = rst_val && von && (x == HV-1) && (y == VV-1);
        sb_q.push_back(e);
        @(posedge clk_0);
        #1;
        e = sb_q.pop_front();
        check($sformatf("%s x%0d y%0d", name, x, y),
              {4'b0, vid.frame_tick, vid.red, vid.green, vid.blue},
              {4'b0, e.tick, e.rgb});
    endtask

    task automatic run_frame(input frame_vec_t v);
        int  c;
        logic btn;
        c         = 0;
        patterned = v.pat;
        auto_en   = v.auto_on;
        for (int y = 0; y < VT; y++) begin
            for (int x = 0; x < HT; x++) begin
                btn = !(v.press_start >= 0 && c >= v.press_start && c < v.press_start + v.press_len);
                drive_cycle(v.name, x, y, btn, 1'b1, v.blank, v.disp);
                c++;
            end
        end
        check({v.name, " sel_end"}, {5'b0, vid.scene_sel}, {5'b0, v.sel_end});
    endtask

    function automatic frame_vec_t fv(input string name, input logic auto_on, input logic pat,
                                      input int ps, input int pl, input logic blank,
                                      input logic [2:0] disp, input logic [2:0] sel_end);
        frame_vec_t v;
        v.name = name; v.auto_on = auto_on; v.pat = pat;
        v.press_start = ps; v.press_len = pl; v.blank = blank;
        v.disp = disp; v.sel_end = sel_end;
        return v;
    endfunction

    initial begin
        //                  name           auto pat  ps  pl blank disp end
        vecs.push_back(fv("auto_f0",      1, 0, -1,  0, 0, 0, 0));
        vecs.push_back(fv("auto_f1",      1, 0, -1,  0, 0, 0, 1));
        vecs.push_back(fv("auto_blank",   1, 0, -1,  0, 1, 0, 1));
        vecs.push_back(fv("glitch",       0, 1,  2,  3, 0, 1, 1));
        vecs.push_back(fv("press_pend",   0, 1,  2, 10, 0, 1, 2));
        vecs.push_back(fv("press_blank",  0, 1, -1,  0, 1, 0, 2));
        vecs.push_back(fv("wrap_pend",    0, 1,  2, 10, 0, 2, 0));
        vecs.push_back(fv("wrap_blank",   0, 1, -1,  0, 1, 0, 0));
        vecs.push_back(fv("show0",        0, 1, -1,  0, 0, 0, 0));
        vecs.push_back(fv("auto2_f0",     1, 1, -1,  0, 0, 0, 0));
        vecs.push_back(fv("auto2_f1",     1, 1, -1,  0, 0, 0, 1));
        vecs.push_back(fv("blank_press",  1, 1,  2, 10, 1, 0, 1));
        vecs.push_back(fv("after_ign_f0", 1, 1, -1,  0, 0, 1, 1));
        vecs.push_back(fv("after_ign_f1", 1, 1, -1,  0, 0, 1, 2));
        vecs.push_back(fv("auto3_blank",  1, 1, -1,  0, 1, 0, 2));
        vecs.push_back(fv("both_f0",      1, 1, -1,  0, 0, 2, 2));
        vecs.push_back(fv("both_f1",      1, 1,  2, 10, 0, 2, 0));
        vecs.push_back(fv("both_blank",   1, 1, -1,  0, 1, 0, 0));
        vecs.push_back(fv("both_after",   0, 1, -1,  0, 0, 0, 0));

        // Reset held across active pixels, including the frame_end position.
        drive_cycle("reset", 3, 1, 1'b1, 1'b0, 1'b0, 3'd0);
        drive_cycle("reset", 7, 3, 1'b1, 1'b0, 1'b0, 3'd0);
        drive_cycle("reset", 8, 3, 1'b1, 1'b0, 1'b0, 3'd0);
        check("reset sel", {5'b0, vid.scene_sel}, 8'd0);

        foreach (vecs[i]) run_frame(vecs[i]);

        // Reset in the middle of a BLANK frame returns to SHOW on scene 0.
        run_frame(fv("rst_pend", 0, 1, 2, 10, 0, 0, 1));
        for (int c = 0; c < 15; c++)
            drive_cycle("rst_blank_pre", c % HT, c / HT, 1'b1, 1'b1, 1'b1, 3'd1);
        drive_cycle("rst_blank", 5, 1, 1'b1, 1'b0, 1'b1, 3'd1);
        check("rst_blank sel", {5'b0, vid.scene_sel}, 8'd0);
        run_frame(fv("rst_after", 0, 1, -1, 0, 0, 0, 0));

        check("sb_drain", 8'(sb_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scene_sequencer.md
SCENE_SEQUENCER -- requirements
Module: scene_sequencer

Interface
REQ-001 SHALL take parameter NUM_SCENES, default 4, number of scene generators multiplexed (2..8).
REQ-002 SHALL take parameter FRAMES_PER_SCENE, default 300, frames shown before auto-advance (1..1023).
REQ-003 SHALL take parameter DEBOUNCE_CYCLES, default 250000, stable cycles required on btn_next (10 ms at 25 MHz).
REQ-004 SHALL take parameters h_video, default 640, and v_video, default 480, active video size.
REQ-005 clk_0  input  1  25 MHz pixel clock.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 pixel_x  input  10  current horizontal pixel from timing generator.
REQ-008 pixel_y  input  10  current vertical line from timing generator.
REQ-009 video_on  input  1  high inside active video region.
REQ-010 btn_next  input  1  raw asynchronous push button, active-low (pressed = 0).
REQ-011 auto_en  input  1  high enables timed auto-advance.
REQ-012 scene_rgb  input  3*NUM_SCENES  packed {red,green,blue} per scene; scene k at bits [3k+2:3k], red MSB.
REQ-013 red, green, blue  output  1 each  registered colour to DAC pins.
REQ-014 scene_sel  output  3  index of scene currently selected.
REQ-015 frame_tick  output  1  one-cycle pulse at end of each active frame.

Function
REQ-016 frame_end SHALL be true in the cycle where video_on=1, pixel_x=h_video-1, pixel_y=v_video-1; frame_tick SHALL be frame_end registered (1-cycle latency).
REQ-017 btn_next SHALL pass a 2-flop synchronizer, then a debounce counter; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-018 A press event SHALL be a single one-cycle pulse on the debounced 1->0 transition; release generates nothing.
REQ-019 Frame counter SHALL increment on each frame_end in SHOW, clear on any scene change, and clear while auto_en=0.
REQ-020 Auto request SHALL assert when auto_en=1 and frame counter reaches FRAMES_PER_SCENE-1 at a frame_end.
REQ-021 FSM states SHALL be SHOW, PENDING, BLANK.
REQ-022 SHOW: press event -> PENDING; auto request (at frame_end) -> BLANK with scene_sel advanced in same cycle.
REQ-023 PENDING: at next frame_end -> BLANK, scene_sel advanced; scene display continues until then.
REQ-024 BLANK: outputs black for one full frame; at next frame_end -> SHOW.
REQ-025 Press events in PENDING or BLANK SHALL be ignored (no queued second advance).
REQ-026 Press and auto request in the same frame SHALL advance scene_sel exactly once.
REQ-027 scene_sel SHALL wrap from NUM_SCENES-1 to 0.
REQ-028 red/green/blue SHALL be registered from scene_rgb[scene_sel] one cycle after inputs, forced 0 when video_on=0 or state=BLANK.
REQ-029 Reset asserted mid-frame or mid-transition SHALL take effect on the next clk_0 edge regardless of state.

Reset
REQ-030 On rst=0: state=SHOW, scene_sel=0, frame counter=0, debounce counter=0, debounced level=1 (released), synchronizer flops=1, red/green/blue=0, frame_tick=0.
REQ-031 While rst=0 all outputs SHALL hold reset values; no press event generated on deassertion.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (2 bits) and the RGB slice width constant (3).
REQ-033 Synchronizer and debouncer SHALL be one sub-module, button_debounce, emitting level and press pulse.
REQ-034 Scene generators SHALL remain outside this block; only their colour bits enter via scene_rgb.

Verification (NUM_SCENES=3, FRAMES_PER_SCENE=2, DEBOUNCE_CYCLES=4, h_video=8, v_video=4)
REQ-035 Reset then auto_en=1, scene 0 all-red -> red=1 in active pixels for 2 frames, black 1 frame, then scene_sel=1.
REQ-036 btn_next low 3 cycles then high -> no press event, scene_sel unchanged.
REQ-037 btn_next low 10 cycles mid-frame -> PENDING, scene continues to frame_end, one black frame, scene_sel=1.
REQ-038 scene_sel=2, press -> after BLANK scene_sel=0 (wrap).
REQ-039 Press during BLANK plus auto request same frame -> scene_sel advances by exactly 1.
REQ-040 rst=0 during BLANK -> next cycle state=SHOW, scene_sel=0, RGB=0.
